coef_bank_pingpong: RTL and testbench
=====================================

Name: coef_bank_pingpong

Overview:
Double-buffered (ping-pong) coefficient/data bank for the single-MACC interpolator datapath. It holds 2 pages × 2**chWidth channels × 2**addrWidth words. The writer fills the shadow page while the MACC reads the active page. A swap request exchanges the pages only when the read side is idle, so the MACC never sees a half-updated coefficient set mid-burst. The read path has parametrised latency and a valid strobe.

Parameters:
addrWidth, 8, word address width per channel page
dataWidth, 18, data word width
chWidth, 1, channel-select width; 2**chWidth channels
outReg, 1, 0 or 1; adds an output pipeline register (read latency 1+outReg)

Ports:
Clk_i  input  1  clock, all logic on rising edge
Rst_n_i  input  1  asynchronous, active-low reset
Wr_i  input  1  write strobe (shadow page)
WrCh_i  input  chWidth  write channel
AddrWr_i  input  addrWidth  write address
Din_i  input  dataWidth  write data
Rd_i  input  1  read strobe (active page)
RdCh_i  input  chWidth  read channel
Addr_i  input  addrWidth  read address
Swap_i  input  1  page-swap request pulse
Dout_o  output  dataWidth  read data
DoutValid_o  output  1  Dout_o carries the result of a read this cycle
ActivePage_o  output  1  page currently read (0/1)
SwapPending_o  output  1  swap requested, not yet applied
SwapDone_o  output  1  one-cycle pulse the cycle after the page flips

Behaviour:
- Reset (async assert, sync release): ActivePage_o=0, SwapPending_o=0, SwapDone_o=0, DoutValid_o=0, Dout_o=0. All in-flight read pipeline stages are cleared. Memory contents are not reset.
- Storage: one array indexed {page, ch, addr}. Synchronous write, synchronous registered read. The array must infer block RAM.
- Write: if Wr_i=1 at an edge, mem[{~active, WrCh_i, AddrWr_i}] <= Din_i. Writes are always allowed, including while a swap is pending.
- Read: Rd_i=1 at edge N captures {active, RdCh_i, Addr_i}. The page is sampled at issue.
  - outReg=0: data on Dout_o after edge N+1, with DoutValid_o=1 for that cycle only.
  - outReg=1: data after edge N+2, with DoutValid_o=1 for that cycle only.
  - Back-to-back reads give one result per cycle.
- Dout_o holds its last value when DoutValid_o=0. It does not update on cycles without a read result.
- Read/write collision cannot occur, because reads and writes always target different pages. No bypass logic is needed.
- Swap control (two states, IDLE/PENDING):
  - IDLE, Swap_i=1, Rd_i=0: flip the page at this edge. SwapDone_o=1 next cycle. Stay in IDLE.
  - IDLE, Swap_i=1, Rd_i=1: go to PENDING, SwapPending_o=1.
  - PENDING: at the first edge with Rd_i=0, flip the page, go to IDLE, SwapPending_o=0, SwapDone_o=1 next cycle.
  - Swap_i while in PENDING is ignored. Requests are not queued or counted.
- Page flip is effective from the next cycle. A write in the flip cycle lands in the old shadow page, which becomes active. A read issued in the flip cycle is impossible, since a flip requires Rd_i=0.
- Reads already in flight at the flip complete with old-page data.
- Reset mid-operation: a pending swap is dropped, the active page returns to 0, and any in-flight DoutValid_o is suppressed.

Test Plan:
1. Reset, then write page1 (shadow) ch0 addr5=0x155AA, Swap_i with Rd_i=0, then read ch0 addr5. Expect SwapDone_o=1 one cycle after the swap, ActivePage_o=1, and Dout_o=0x155AA with DoutValid_o=1 exactly 2 cycles after Rd_i (outReg=1).
2. Channel isolation: write ch0 addr3=0x00011 and ch1 addr3=0x00022 to the shadow page, swap, then read ch1 addr3 followed by ch0 addr3 back-to-back. Expect 0x00022 then 0x00011 on consecutive cycles, with DoutValid_o high for 2 cycles.
3. Deferred swap: hold Rd_i=1 for 10 cycles and pulse Swap_i at cycle 2 and again at cycle 5. Expect SwapPending_o=1 from cycle 3 until Rd_i drops, a single page flip at the first Rd_i=0 edge, and exactly one SwapDone_o pulse.
4. In-flight across flip: issue the last read of page0 (value 0x0ABCD) at cycle N and drop Rd_i with Swap_i at N+1. Expect Dout_o=0x0ABCD at N+2 despite ActivePage_o=1.
5. Writes during pending: while PENDING, write shadow addr7=0x3FFFF, then release reads. After the flip, reading addr7 returns 0x3FFFF.
6. Async reset mid-read: assert Rst_n_i between read issue and result. Expect DoutValid_o=0, Dout_o=0, ActivePage_o=0 and SwapPending_o=0 immediately, with no valid strobe after release.

Source files
------------

// File: rtl/coef_bank_pingpong.sv
// Ping-pong coefficient bank: the writer fills the shadow page while reads hit the active page.
// Page swaps are deferred until the read side is idle, so a read burst always sees one coherent page.
module coef_bank_pingpong #(
    parameter int unsigned addrWidth = 8,
    parameter int unsigned dataWidth = 18,
    parameter int unsigned chWidth   = 1,
    parameter int unsigned outReg    = 1
) (
    input  logic                 Clk_i,
    input  logic                 Rst_n_i,
    input  logic                 Wr_i,
    input  logic [chWidth-1:0]   WrCh_i,
    input  logic [addrWidth-1:0] AddrWr_i,
    input  logic [dataWidth-1:0] Din_i,
    input  logic                 Rd_i,
    input  logic [chWidth-1:0]   RdCh_i,
    input  logic [addrWidth-1:0] Addr_i,
    input  logic                 Swap_i,
    output logic [dataWidth-1:0] Dout_o,
    output logic                 DoutValid_o,
    output logic                 ActivePage_o,
    output logic                 SwapPending_o,
    output logic                 SwapDone_o
);

    localparam int unsigned MEM_AW = 1 + chWidth + addrWidth;
    localparam int unsigned DEPTH  = 2 ** MEM_AW;

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_PENDING = 1'b1
    } state_t;

    logic [dataWidth-1:0] r_mem [0:DEPTH-1];
    logic [MEM_AW-1:0]    r_rd_addr;
    logic [dataWidth-1:0] r_ram_q;
    logic                 r_rd_vld0;
    logic                 r_rd_vld1;
    logic                 r_active;
    logic                 r_swap_done;
    state_t               r_state;
    state_t               w_state_nxt;
    logic                 w_flip;
    logic [dataWidth-1:0] w_dout;
    logic                 w_dout_vld;

    // Swap FSM: state register
    always_ff @(posedge Clk_i or negedge Rst_n_i) begin
        if (!Rst_n_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Swap FSM: next state; a request that meets an active read is parked
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (Swap_i && Rd_i) w_state_nxt = S_PENDING;
            S_PENDING: if (!Rd_i)          w_state_nxt = S_IDLE;
            default:                       w_state_nxt = S_IDLE;
        endcase
    end

    // Swap FSM: flip decode; Swap_i during PENDING is deliberately ignored
    always_comb begin
        w_flip = 1'b0;
        case (r_state)
            S_IDLE:    w_flip = Swap_i && !Rd_i;
            S_PENDING: w_flip = !Rd_i;
            default:   w_flip = 1'b0;
        endcase
    end

    always_ff @(posedge Clk_i or negedge Rst_n_i) begin
        if (!Rst_n_i) begin
            r_active    <= 1'b0;
            r_swap_done <= 1'b0;
        end else begin
            r_active    <= r_active ^ w_flip;
            r_swap_done <= w_flip;
        end
    end

    // Shadow-page write; a write in the flip cycle still targets the pre-flip shadow
    always_ff @(posedge Clk_i) begin
        if (Wr_i) begin
            r_mem[{~r_active, WrCh_i, AddrWr_i}] <= Din_i;
        end
    end

    // Read address capture: the page is frozen at issue
    always_ff @(posedge Clk_i) begin
        if (Rd_i) begin
            r_rd_addr <= {r_active, RdCh_i, Addr_i};
        end
    end

    always_ff @(posedge Clk_i or negedge Rst_n_i) begin
        if (!Rst_n_i) begin
            r_rd_vld0 <= 1'b0;
            r_rd_vld1 <= 1'b0;
        end else begin
            r_rd_vld0 <= Rd_i;
            r_rd_vld1 <= r_rd_vld0;
        end
    end

    // RAM data register; only updates on a real read so the output holds otherwise
    always_ff @(posedge Clk_i or negedge Rst_n_i) begin
        if (!Rst_n_i) begin
            r_ram_q <= '0;
        end else if (r_rd_vld0) begin
            r_ram_q <= r_mem[r_rd_addr];
        end
    end

    if (outReg != 0) begin : g_oreg
        logic [dataWidth-1:0] r_dout;
        logic                 r_dout_vld;

        always_ff @(posedge Clk_i or negedge Rst_n_i) begin
            if (!Rst_n_i) begin
                r_dout     <= '0;
                r_dout_vld <= 1'b0;
            end else begin
                r_dout_vld <= r_rd_vld1;
                if (r_rd_vld1) begin
                    r_dout <= r_ram_q;
                end
            end
        end

        assign w_dout     = r_dout;
        assign w_dout_vld = r_dout_vld;
    end else begin : g_noreg
        assign w_dout     = r_ram_q;
        assign w_dout_vld = r_rd_vld1;
    end

    assign Dout_o        = w_dout;
    assign DoutValid_o   = w_dout_vld;
    assign ActivePage_o  = r_active;
    assign SwapPending_o = (r_state == S_PENDING);
    assign SwapDone_o    = r_swap_done;

endmodule

// File: tb/tb_coef_bank_pingpong.sv
// Directed bench for coef_bank_pingpong (default parameters, outReg=1: read latency 2).
module tb_coef_bank_pingpong;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 18;
    localparam int unsigned CW = 1;

    logic          clk;
    logic          rst_n;
    logic          wr;
    logic [CW-1:0] wr_ch;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] din;
    logic          rd;
    logic [CW-1:0] rd_ch;
    logic [AW-1:0] rd_addr;
    logic          swap;
    logic [DW-1:0] dout;
    logic          dout_vld;
    logic          active;
    logic          pending;
    logic          done;

    int errors = 0;
    int checks = 0;

    coef_bank_pingpong #(
        .addrWidth(AW), .dataWidth(DW), .chWidth(CW), .outReg(1)
    ) dut (
        .Clk_i(clk), .Rst_n_i(rst_n),
        .Wr_i(wr), .WrCh_i(wr_ch), .AddrWr_i(wr_addr), .Din_i(din),
        .Rd_i(rd), .RdCh_i(rd_ch), .Addr_i(rd_addr), .Swap_i(swap),
        .Dout_o(dout), .DoutValid_o(dout_vld), .ActivePage_o(active),
        .SwapPending_o(pending), .SwapDone_o(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          wr;
        logic [CW-1:0] wch;
        logic [AW-1:0] waddr;
        logic [DW-1:0] din;
        logic          rd;
        logic [CW-1:0] rch;
        logic [AW-1:0] raddr;
        logic          swap;
        logic [DW-1:0] e_dout;
        logic          e_vld;
        logic          e_act;
        logic          e_pend;
        logic          e_done;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic w, input logic [CW-1:0] wc, input logic [AW-1:0] wa,
                       input logic [DW-1:0] d, input logic r, input logic [CW-1:0] rc,
                       input logic [AW-1:0] ra, input logic s, input logic [DW-1:0] ed,
                       input logic ev, input logic ea, input logic ep, input logic edn);
        vec_t v;
        v.wr = w; v.wch = wc; v.waddr = wa; v.din = d;
        v.rd = r; v.rch = rc; v.raddr = ra; v.swap = s;
        v.e_dout = ed; v.e_vld = ev; v.e_act = ea; v.e_pend = ep; v.e_done = edn;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [DW-1:0] ed, input logic ev,
                             input logic ea, input logic ep, input logic edn);
        check({tag, ".dout"},    32'(dout),     32'(ed));
        check({tag, ".valid"},   32'(dout_vld), 32'(ev));
        check({tag, ".active"},  32'(active),   32'(ea));
        check({tag, ".pending"}, 32'(pending),  32'(ep));
        check({tag, ".done"},    32'(done),     32'(edn));
    endtask

    // Drive one cycle at the falling edge, then sample 1 ns after the rising edge
    task automatic cycle(input logic w, input logic [CW-1:0] wc, input logic [AW-1:0] wa,
                         input logic [DW-1:0] d, input logic r, input logic [CW-1:0] rc,
                         input logic [AW-1:0] ra, input logic s);
        @(negedge clk);
        wr = w; wr_ch = wc; wr_addr = wa; din = d;
        rd = r; rd_ch = rc; rd_addr = ra; swap = s;
        @(posedge clk);
        #1;
    endtask

    int done_cnt;

    initial begin
        rst_n = 1'b0;
        wr = 1'b0; wr_ch = '0; wr_addr = '0; din = '0;
        rd = 1'b0; rd_ch = '0; rd_addr = '0; swap = 1'b0;

        // Single-page flows: write, swap, readback, channel isolation, in-flight across flip
        //   wr wch wa    din       rd rch ra   sw  dout      v  act pend done
        add(0, 0, 8'd0, 18'h0,     0, 0, 8'd0, 0, 18'h0,     0, 0, 0, 0);
        add(1, 0, 8'd5, 18'h155AA, 0, 0, 8'd0, 0, 18'h0,     0, 0, 0, 0);
        add(0, 0, 8'd0, 18'h0,     0, 0, 8'd0, 1, 18'h0,     0, 1, 0, 1);
        add(0, 0, 8'd0, 18'h0,     1, 0, 8'd5, 0, 18'h0,     0, 1, 0, 0);
        add(0, 0, 8'd0, 18'h0,     0, 0, 8'd0, 0, 18'h0,     0, 1, 0, 0);
        add(0, 0, 8'd0, 18'h0,     0, 0, 8'd0, 0, 18'h155AA, 1, 1, 0, 0);
        add(0, 0, 8'd0, 18'h0,     0, 0, 8'd0, 0, 18'h155AA, 0, 1, 0, 0);
        add(1, 0, 8'd3, 18'h00011, 0, 0, 8'd0, 0, 18'h155AA, 0, 1, 0, 0);
        add(1, 1, 8'd3, 18'h00022, 0, 0, 8'd0, 0, 18'h155AA, 0, 1, 0, 0);
        add(0, 0, 8'd0, 18'h0,     0, 0, 8'd0, 1, 18'h155AA, 0, 0, 0, 1);
        add(0, 0, 8'd0, 18'h0,     1, 1, 8'd3, 0, 18'h155AA, 0, 0, 0, 0);
        add(0, 0, 8'd0, 18'h0,     1, 0, 8'd3, 0, 18'h155AA, 0, 0, 0, 0);
        add(0, 0, 8'd0, 18'h0,     0, 0, 8'd0, 0, 18'h00022, 1, 0, 0, 0);
        add(0, 0, 8'd0, 18'h0,     0, 0, 8'd0, 0, 18'h00011, 1, 0, 0, 0);
        add(0, 0, 8'd0, 18'h0,     0, 0, 8'd0, 0, 18'h00011, 0, 0, 0, 0);
        add(1, 0, 8'd9, 18'h01234, 0, 0, 8'd0, 0, 18'h00011, 0, 0, 0, 0);
        add(0, 0, 8'd0, 18'h0,     0, 0, 8'd0, 1, 18'h00011, 0, 1, 0, 1);
        add(1, 0, 8'd9, 18'h0ABCD, 0, 0, 8'd0, 0, 18'h00011, 0, 1, 0, 0);
        add(0, 0, 8'd0, 18'h0,     0, 0, 8'd0, 1, 18'h00011, 0, 0, 0, 1);
        add(0, 0, 8'd0, 18'h0,     1, 0, 8'd9, 0, 18'h00011, 0, 0, 0, 0);
        add(0, 0, 8'd0, 18'h0,     0, 0, 8'd0, 1, 18'h00011, 0, 1, 0, 1);
        add(0, 0, 8'd0, 18'h0,     0, 0, 8'd0, 0, 18'h0ABCD, 1, 1, 0, 0);
        add(0, 0, 8'd0, 18'h0,     0, 0, 8'd0, 0, 18'h0ABCD, 0, 1, 0, 0);
        add(0, 0, 8'd0, 18'h0,     1, 0, 8'd9, 0, 18'h0ABCD, 0, 1, 0, 0);
        add(0, 0, 8'd0, 18'h0,     0, 0, 8'd0, 0, 18'h0ABCD, 0, 1, 0, 0);
        add(0, 0, 8'd0, 18'h0,     0, 0, 8'd0, 0, 18'h01234, 1, 1, 0, 0);
        // Write in the flip cycle lands in the page that becomes active
        add(1, 0, 8'd4, 18'h2AAAA, 0, 0, 8'd0, 1, 18'h01234, 0, 0, 0, 1);
        add(0, 0, 8'd0, 18'h0,     1, 0, 8'd4, 0, 18'h01234, 0, 0, 0, 0);
        add(0, 0, 8'd0, 18'h0,     0, 0, 8'd0, 0, 18'h01234, 0, 0, 0, 0);
        add(0, 0, 8'd0, 18'h0,     0, 0, 8'd0, 0, 18'h2AAAA, 1, 0, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 18'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            cycle(vecs[i].wr, vecs[i].wch, vecs[i].waddr, vecs[i].din,
                  vecs[i].rd, vecs[i].rch, vecs[i].raddr, vecs[i].swap);
            check_all($sformatf("vec%0d", i), vecs[i].e_dout, vecs[i].e_vld,
                      vecs[i].e_act, vecs[i].e_pend, vecs[i].e_done);
        end

        // Deferred swap under a 10-cycle read burst, second request ignored, write while pending
        done_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            cycle((c == 4), 1'b0, 8'd7, 18'h3FFFF, 1'b1, 1'b0, 8'd4, (c == 2 || c == 5));
            if (done) done_cnt++;
            check_all($sformatf("burst%0d", c), 18'h2AAAA, (c >= 2), 1'b0, (c >= 2), 1'b0);
        end
        cycle(1'b0, 1'b0, 8'd0, 18'h0, 1'b0, 1'b0, 8'd0, 1'b0);
        if (done) done_cnt++;
        check_all("release", 18'h2AAAA, 1'b1, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 8'd0, 18'h0, 1'b0, 1'b0, 8'd0, 1'b0);
        if (done) done_cnt++;
        check_all("release+1", 18'h2AAAA, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 8'd0, 18'h0, 1'b1, 1'b0, 8'd7, 1'b0);
        if (done) done_cnt++;
        cycle(1'b0, 1'b0, 8'd0, 18'h0, 1'b0, 1'b0, 8'd0, 1'b0);
        if (done) done_cnt++;
        cycle(1'b0, 1'b0, 8'd0, 18'h0, 1'b0, 1'b0, 8'd0, 1'b0);
        if (done) done_cnt++;
        check_all("pending_wr", 18'h3FFFF, 1'b1, 1'b1, 1'b0, 1'b0);
        check("done_pulses", 32'(done_cnt), 32'd1);

        // Async reset between read issue and result, with a swap parked
        cycle(1'b0, 1'b0, 8'd0, 18'h0, 1'b1, 1'b0, 8'd7, 1'b1);
        check("pre_rst.pending", 32'(pending), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", 18'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rd = 1'b0; swap = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            check_all($sformatf("post_rst%0d", c), 18'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
